mac_row_dm: RTL and testbench

MAC_ROW_DM -- requirements
Module: mac_row_dm

---
 rtl/mac_row_dm.sv | 141 ++++++++++++++
 tb/tb_mac_row_dm.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_dm.sv
// One row of dual-mode (weight-stationary / output-stationary) MAC PEs.
// Operands and instructions ripple west to east one PE per cycle; psums flow north to south.
module mac_row_dm #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [bw-1:0]            in_w,
  input  logic [1:0]               inst_w,
  input  logic [psum_bw*col-1:0]   in_n,
  input  logic                     mode,
  input  logic                     rearm,
  output logic [psum_bw*col-1:0]   out_s,
  output logic [col-1:0]           valid,
  output logic [col-1:0]           load_done
);

  logic [bw-1:0]      a_q   [col];
  logic [bw-1:0]      a_d   [col];
  logic [bw-1:0]      b_q   [col];
  logic [bw-1:0]      b_d   [col];
  logic [1:0]         inst_q[col];
  logic [1:0]         inst_d[col];
  logic [psum_bw-1:0] out_q [col];
  logic [psum_bw-1:0] out_d [col];
  logic [psum_bw-1:0] acc_q [col];
  logic [psum_bw-1:0] acc_d [col];
  logic [col-1:0]     v_q, v_d;
  logic [col-1:0]     ready_q, ready_d;
  logic               mode_q;
  logic               mode_chg;

  logic [bw-1:0]      x   [col];
  logic [1:0]         ins [col];

  // Unsigned activation times signed weight; the low psum_bw bits of the
  // extended product are the wrapped result.
  function automatic logic [psum_bw-1:0] mul(input logic [bw-1:0] xv, input logic [bw-1:0] wv);
    logic [psum_bw-1:0] xe;
    logic [psum_bw-1:0] we;
    xe = {{(psum_bw-bw){1'b0}}, xv};
    we = {{(psum_bw-bw){wv[bw-1]}}, wv};
    return xe * we;
  endfunction

  assign mode_chg = (mode != mode_q);

  always_comb begin
    x[0]   = in_w;
    ins[0] = inst_w;
    for (int i = 1; i < col; i++) begin
      x[i]   = a_q[i-1];
      ins[i] = inst_q[i-1];
    end
  end

  always_comb begin
    logic [psum_bw-1:0] lane;
    logic [bw-1:0]      wgt;
    v_d     = '0;
    ready_d = ready_q;
    for (int i = 0; i < col; i++) begin
      lane      = in_n[psum_bw*i +: psum_bw];
      wgt       = lane[bw-1:0];
      a_d[i]    = (ins[i] != 2'b00) ? x[i] : a_q[i];
      b_d[i]    = b_q[i];
      inst_d[i] = ins[i];
      out_d[i]  = out_q[i];
      acc_d[i]  = acc_q[i];
      if (mode_chg) begin
        ready_d[i] = 1'b1;
        acc_d[i]   = '0;
      end else if (!mode) begin
        // A load consumed here must not reach the next PE.
        inst_d[i] = {ins[i][1], ins[i][0] & ~ready_q[i]};
        if (ins[i][0] && ready_q[i]) begin
          if (!rearm) b_d[i] = x[i];
          ready_d[i] = 1'b0;
        end
        if (ins[i][1]) begin
          out_d[i] = lane + mul(x[i], b_q[i]);
          v_d[i]   = 1'b1;
        end
      end else begin
        case (ins[i])
          2'b10: begin
            acc_d[i] = acc_q[i] + mul(x[i], wgt);
            out_d[i] = {{(psum_bw-bw){1'b0}}, wgt};
          end
          2'b01: begin
            out_d[i] = acc_q[i];
            acc_d[i] = '0;
            v_d[i]   = 1'b1;
          end
          2'b11: begin
            out_d[i] = acc_q[i] + mul(x[i], wgt);
            acc_d[i] = '0;
            v_d[i]   = 1'b1;
          end
          default: ;
        endcase
      end
      if (rearm) ready_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        inst_q[i] <= '0;
        out_q[i]  <= '0;
        acc_q[i]  <= '0;
      end
      v_q     <= '0;
      ready_q <= '1;
      mode_q  <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        a_q[i]    <= a_d[i];
        b_q[i]    <= b_d[i];
        inst_q[i] <= inst_d[i];
        out_q[i]  <= out_d[i];
        acc_q[i]  <= acc_d[i];
      end
      v_q     <= v_d;
      ready_q <= ready_d;
      mode_q  <= mode;
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_lane
    assign out_s[psum_bw*g +: psum_bw] = out_q[g];
  end
  assign valid     = v_q;
  assign load_done = ~ready_q;

endmodule

// File: tb/tb_mac_row_dm.sv
// Bench for mac_row_dm: directed scenarios plus random traffic against a
// packet/age-based reference model of the row.
module tb_mac_row_dm;
  localparam int BW  = 4;
  localparam int PW  = 16;
  localparam int COL = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW-1:0]     in_w;
  logic [1:0]        inst_w;
  logic [PW*COL-1:0] in_n;
  logic              mode;
  logic              rearm;
  logic [PW*COL-1:0] out_s;
  logic [COL-1:0]    valid;
  logic [COL-1:0]    load_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-PE weight/accumulator/output and a history of
  // packets that entered at the west edge (index = age in cycles).
  logic [BW-1:0]  mb   [COL];
  logic [PW-1:0]  macc [COL];
  logic [PW-1:0]  mout [COL];
  logic [COL-1:0] mv;
  logic [COL-1:0] mready;
  logic           mmode_q;
  logic [BW-1:0]  hx   [$];
  logic [1:0]     hins [$];

  mac_row_dm #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_w     (in_w),
    .inst_w   (inst_w),
    .in_n     (in_n),
    .mode     (mode),
    .rearm    (rearm),
    .out_s    (out_s),
    .valid    (valid),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] prod(input logic [BW-1:0] xv, input logic [BW-1:0] wv);
    int sw;
    sw = wv[BW-1] ? int'(wv) - (1 << BW) : int'(wv);
    return PW'(int'(xv) * sw);
  endfunction

  function automatic logic [PW*COL-1:0] exp_out();
    logic [PW*COL-1:0] r;
    for (int i = 0; i < COL; i++) r[PW*i +: PW] = mout[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < COL; i++) begin
      mb[i] = '0; macc[i] = '0; mout[i] = '0;
    end
    mv = '0; mready = '1; mmode_q = 1'b0;
    hx.delete(); hins.delete();
  endtask

  task automatic model_edge();
    logic          chg;
    logic [BW-1:0] x;
    logic [1:0]    ins;
    logic [PW-1:0] lane;
    logic [BW-1:0] w;
    chg = (mode !== mmode_q);
    hx.push_front(in_w);
    hins.push_front(inst_w);
    if (hx.size() > COL) begin
      void'(hx.pop_back());
      void'(hins.pop_back());
    end
    for (int i = 0; i < COL; i++) begin
      x    = (i < hx.size()) ? hx[i] : '0;
      ins  = (i < hins.size()) ? hins[i] : 2'b00;
      lane = in_n[PW*i +: PW];
      w    = lane[BW-1:0];
      mv[i] = 1'b0;
      if (chg) begin
        mready[i] = 1'b1;
        macc[i]   = '0;
      end else if (!mode) begin
        if (ins[1]) begin
          mout[i] = lane + prod(x, mb[i]);
          mv[i]   = 1'b1;
        end
        if (ins[0] && mready[i]) begin
          if (!rearm) mb[i] = x;
          mready[i] = 1'b0;
          hins[i]   = ins & 2'b10;
        end
      end else begin
        case (ins)
          2'b10: begin
            macc[i] = macc[i] + prod(x, w);
            mout[i] = {{(PW-BW){1'b0}}, w};
          end
          2'b01: begin
            mout[i] = macc[i]; macc[i] = '0; mv[i] = 1'b1;
          end
          2'b11: begin
            mout[i] = macc[i] + prod(x, w); macc[i] = '0; mv[i] = 1'b1;
          end
          default: ;
        endcase
      end
      if (rearm) mready[i] = 1'b1;
    end
    mmode_q = mode;
  endtask

  task automatic step(input logic [BW-1:0] x, input logic [1:0] ins);
    in_w   = x;
    inst_w = ins;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_lanes(input logic [PW-1:0] v);
    for (int i = 0; i < COL; i++) in_n[PW*i +: PW] = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 2'b00);
  endtask

  task automatic test_reset();
    checks++;
    if (out_s !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_s); end
    checks++;
    if (valid !== '0) begin errors++; $display("FAIL reset_valid: got %h expected 0", valid); end
    checks++;
    if (load_done !== 8'h00) begin
      errors++; $display("FAIL reset_load_done: got %h expected 00", load_done);
    end
  endtask

  task automatic test_ws_load();
    logic [COL-1:0] exp_ld;
    logic [PW-1:0]  exp_l;
    set_lanes('0);
    for (int k = 0; k < 16; k++) begin
      step((k < 8) ? BW'(k + 1) : '0, 2'b01);
      exp_ld = '0;
      for (int i = 0; i < COL; i++) if (2 * i <= k) exp_ld[i] = 1'b1;
      checks++;
      if (load_done !== exp_ld) begin
        errors++; $display("FAIL ws_load_order k=%0d: got %h expected %h", k, load_done, exp_ld);
      end
    end
    // Weight i+1 read back through an execute with x=1; weight 8 is -8.
    step(4'd1, 2'b10);
    for (int j = 0; j < COL; j++) begin
      if (j > 0) step('0, 2'b00);
      exp_l = (j == 7) ? 16'hFFF8 : PW'(j + 1);
      checks++;
      if (out_s[PW*j +: PW] !== exp_l || valid !== COL'(1 << j)) begin
        errors++;
        $display("FAIL ws_load_weight lane%0d: got %h/%b expected %h/%b",
                 j, out_s[PW*j +: PW], valid, exp_l, COL'(1 << j));
      end
    end
  endtask

  task automatic test_rearm();
    logic [PW-1:0] exp_l;
    rearm = 1'b1;
    step('0, 2'b00);
    rearm = 1'b0;
    checks++;
    if (load_done !== 8'h00) begin
      errors++; $display("FAIL rearm_load_done: got %h expected 00", load_done);
    end
    // Weights survive the re-arm.
    step(4'd1, 2'b10);
    for (int j = 0; j < COL; j++) begin
      if (j > 0) step('0, 2'b00);
      exp_l = (j == 7) ? 16'hFFF8 : PW'(j + 1);
      checks++;
      if (out_s[PW*j +: PW] !== exp_l) begin
        errors++; $display("FAIL rearm_keep_b lane%0d: got %h expected %h",
                           j, out_s[PW*j +: PW], exp_l);
      end
    end
  endtask

  task automatic test_ws_execute();
    for (int k = 0; k < 16; k++) step((k < 8) ? 4'd2 : 4'd0, 2'b01);
    checks++;
    if (load_done !== 8'hFF) begin
      errors++; $display("FAIL ws_reload_done: got %h expected ff", load_done);
    end
    set_lanes(16'd5);
    step(4'd3, 2'b10);
    for (int j = 0; j < COL; j++) begin
      if (j > 0) step('0, 2'b00);
      checks++;
      if (out_s[PW*j +: PW] !== 16'd11 || valid !== COL'(1 << j)) begin
        errors++;
        $display("FAIL ws_exec lane%0d: got %h/%b expected 000b/%b",
                 j, out_s[PW*j +: PW], valid, COL'(1 << j));
      end
      checks++;
      if (out_s !== exp_out()) begin
        errors++; $display("FAIL ws_exec_others j=%0d: got %h expected %h", j, out_s, exp_out());
      end
    end
    step('0, 2'b00);
    checks++;
    if (valid !== '0) begin errors++; $display("FAIL ws_exec_pulse: got %b expected 0", valid); end
  endtask

  task automatic test_signed();
    rearm = 1'b1;
    step('0, 2'b00);
    rearm = 1'b0;
    step(4'hF, 2'b01);
    step('0, 2'b00);
    set_lanes('0);
    step(4'd15, 2'b10);
    checks++;
    if (out_s[PW-1:0] !== 16'hFFF1 || valid[0] !== 1'b1) begin
      errors++; $display("FAIL signed_mac: got %h/%b expected fff1/1", out_s[PW-1:0], valid[0]);
    end
    idle(COL);
  endtask

  task automatic test_os();
    set_lanes('0);
    mode = 1'b1;
    step('0, 2'b00);
    checks++;
    if (load_done !== 8'h00 || valid !== '0) begin
      errors++; $display("FAIL os_enter: got %h/%b expected 00/0", load_done, valid);
    end
    set_lanes(16'd2);
    for (int k = 0; k < 4; k++) begin
      step(4'd3, 2'b10);
      checks++;
      if (out_s[PW-1:0] !== 16'd2 || valid[0] !== 1'b0) begin
        errors++; $display("FAIL os_exec k=%0d: got %h/%b expected 0002/0",
                           k, out_s[PW-1:0], valid[0]);
      end
    end
    step('0, 2'b01);
    checks++;
    if (out_s[PW-1:0] !== 16'd24 || valid[0] !== 1'b1) begin
      errors++; $display("FAIL os_drain: got %h/%b expected 0018/1", out_s[PW-1:0], valid[0]);
    end
    step('0, 2'b01);
    checks++;
    if (out_s[PW-1:0] !== 16'd0 || valid[0] !== 1'b1) begin
      errors++; $display("FAIL os_drain2: got %h/%b expected 0000/1", out_s[PW-1:0], valid[0]);
    end
    idle(COL);
    checks++;
    if (out_s !== exp_out()) begin
      errors++; $display("FAIL os_model: got %h expected %h", out_s, exp_out());
    end
  endtask

  task automatic test_mode_toggle();
    step(4'd5, 2'b10);
    step(4'd5, 2'b10);
    idle(COL);
    mode = 1'b0;
    step('0, 2'b00);
    checks++;
    if (load_done !== 8'h00 || valid !== '0) begin
      errors++; $display("FAIL toggle_ws: got %h/%b expected 00/0", load_done, valid);
    end
    idle(COL);
    mode = 1'b1;
    idle(COL + 1);
    step('0, 2'b01);
    checks++;
    if (out_s[PW-1:0] !== 16'd0 || valid[0] !== 1'b1) begin
      errors++; $display("FAIL toggle_acc_clear: got %h/%b expected 0000/1",
                         out_s[PW-1:0], valid[0]);
    end
    idle(COL);
    mode = 1'b0;
    idle(COL + 1);
  endtask

  task automatic test_reset_async();
    for (int k = 0; k < 12; k++) begin
      set_lanes(PW'($urandom));
      step(BW'($urandom), (k < 6) ? 2'b01 : 2'b11);
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_s !== '0 || valid !== '0 || load_done !== 8'h00) begin
      errors++; $display("FAIL async_reset: got %h/%b/%h expected 0/0/00", out_s, valid, load_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < COL + 2; k++) begin
      step('0, 2'b00);
      checks++;
      if (valid !== '0) begin
        errors++; $display("FAIL post_reset_valid k=%0d: got %b expected 0", k, valid);
      end
    end
  endtask

  task automatic test_random(input logic m);
    if (mode !== m) begin
      idle(COL);
      mode = m;
      idle(COL + 1);
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < COL; i++) in_n[PW*i +: PW] = PW'($urandom);
      rearm = ($urandom_range(0, 15) == 0);
      step(BW'($urandom), 2'($urandom));
      rearm = 1'b0;
      checks++;
      if (out_s !== exp_out()) begin
        errors++; $display("FAIL rnd_out m=%0d c=%0d: got %h expected %h", m, c, out_s, exp_out());
      end
      checks++;
      if (valid !== mv) begin
        errors++; $display("FAIL rnd_valid m=%0d c=%0d: got %b expected %b", m, c, valid, mv);
      end
      checks++;
      if (load_done !== ~mready) begin
        errors++; $display("FAIL rnd_load_done m=%0d c=%0d: got %h expected %h",
                           m, c, load_done, ~mready);
      end
    end
    idle(COL);
  endtask

  initial begin
    reset  = 1'b1;
    in_w   = '0;
    inst_w = 2'b00;
    in_n   = '0;
    mode   = 1'b0;
    rearm  = 1'b0;
    model_reset();
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_ws_load();
    test_rearm();
    test_ws_execute();
    test_signed();
    test_os();
    test_mode_toggle();
    test_reset_async();
    test_random(1'b0);
    test_random(1'b1);
    test_random(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
